// File: rtl/pc_queue_unit.sv
// Two-entry PC queue (front/back) with delayed-branch and nullify handling.
// Optional taken-branch counter enabled by defining PCQ_BRANCH_CNT_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | normal flow; branches and nullify requests are honoured
// ST_NULLIFY | instruction entering b_pc is squashed; it cannot branch/nullify
module pc_queue_unit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       le,
    input  logic       br_taken,
    input  logic [7:0] ta,
    input  logic       nullify_in,
    output logic [7:0] f_pc,
    output logic [7:0] b_pc,
    output logic [7:0] nxt_pc,
    output logic       squash,
    output logic [7:0] br_cnt
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_NULLIFY = 1'b1
    } state_t;

    localparam logic [7:0] RST_B_PC = 8'h00;
    localparam logic [7:0] RST_F_PC = 8'h04;
    localparam logic [7:0] PC_STEP  = 8'h04;

    state_t     state_q, state_d;
    logic [7:0] f_pc_q, f_pc_d;
    logic [7:0] b_pc_q, b_pc_d;
    logic       squash_q, squash_d;
    logic       take_branch;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            f_pc_q   <= RST_F_PC;
            b_pc_q   <= RST_B_PC;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            f_pc_q   <= f_pc_d;
            b_pc_q   <= b_pc_d;
            squash_q <= squash_d;
        end
    end

    // A nullified instruction's branch request never redirects fetch.
    assign take_branch = (state_q == ST_RUN) && br_taken;
    assign nxt_pc      = take_branch ? {ta[7:2], 2'b00} : (f_pc_q + PC_STEP);

    always_comb begin
        state_d  = state_q;
        f_pc_d   = f_pc_q;
        b_pc_d   = b_pc_q;
        squash_d = squash_q;
        if (le) begin
            b_pc_d = f_pc_q;
            f_pc_d = nxt_pc;
            case (state_q)
                ST_RUN: begin
                    if (nullify_in) begin
                        state_d  = ST_NULLIFY;
                        squash_d = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        squash_d = 1'b0;
                    end
                end
                ST_NULLIFY: begin
                    state_d  = ST_RUN;
                    squash_d = 1'b0;
                end
                default: begin
                    state_d  = ST_RUN;
                    squash_d = 1'b0;
                end
            endcase
        end
    end

`ifdef PCQ_BRANCH_CNT_EN
    logic [7:0] br_cnt_q, br_cnt_d;

    always_comb begin
        br_cnt_d = br_cnt_q;
        if (le && take_branch && (br_cnt_q != 8'hFF)) begin
            br_cnt_d = br_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            br_cnt_q <= 8'h00;
        end else begin
            br_cnt_q <= br_cnt_d;
        end
    end

    assign br_cnt = br_cnt_q;
`else
    assign br_cnt = 8'h00;
`endif

    assign f_pc   = f_pc_q;
    assign b_pc   = b_pc_q;
    assign squash = squash_q;

endmodule

// File: doc/pc_queue_unit.md
PC_QUEUE_UNIT -- requirements
Module: pc_queue_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 le  input  1  load enable; 1 = queue advances this edge, 0 = stall.
REQ-005 br_taken  input  1  branch resolved taken this cycle; ta valid.
REQ-006 ta  input  8  branch target address from target-address generator.
REQ-007 nullify_in  input  1  request to nullify the instruction following the current one.
REQ-008 f_pc  output  8  front PC, the instruction fetch address.
REQ-009 b_pc  output  8  back PC, feeds target-address generator.
REQ-010 nxt_pc  output  8  combinational value f_pc takes on the next advancing edge.
REQ-011 squash  output  1  registered; 1 = instruction now in the slot addressed by b_pc is nullified.
REQ-012 br_cnt  output  8  taken-branch count (see Configuration).

Function
REQ-013 States SHALL be RUN and NULLIFY, 1-bit encoded, registered.
REQ-014 On an edge with le=1: b_pc <= f_pc; f_pc <= nxt_pc.
REQ-015 nxt_pc SHALL be {ta[7:2],2'b00} when state=RUN and br_taken=1, else f_pc+4 modulo 256.
REQ-016 PC arithmetic SHALL be 8-bit unsigned, wrapping 252+4 -> 0 with no flag.
REQ-017 On an edge with le=0: f_pc, b_pc, state, squash, br_cnt SHALL hold; br_taken, ta, nullify_in ignored.
REQ-018 Upstream holds br_taken/ta/nullify_in stable while le=0; block samples them only when le=1.
REQ-019 RUN -> NULLIFY on le=1 and nullify_in=1; squash <= 1 on that edge.
REQ-020 NULLIFY -> RUN on le=1, squash <= 0 on that edge; br_taken and nullify_in SHALL be ignored in NULLIFY (nullified instruction cannot branch or nullify).
REQ-021 RUN with le=1 and nullify_in=0: stay RUN, squash <= 0.
REQ-022 br_taken=1 with nullify_in=1 in RUN: both apply — f_pc <= aligned ta, state -> NULLIFY (delay slot squashed).
REQ-023 Delayed-branch semantics: the instruction at old f_pc (delay slot) still reaches b_pc before the target.
REQ-024 Latency: br_taken at edge N makes f_pc = target after edge N, b_pc = target after the next advancing edge.

Reset
REQ-025 reset_n=0 at a rising edge SHALL set b_pc=0x00, f_pc=0x04, state=RUN, squash=0, br_cnt=0x00.
REQ-026 Reset SHALL take priority over le, br_taken and nullify_in, including mid-stall and in NULLIFY.
REQ-027 Outputs SHALL be undefined before the first reset edge; no asynchronous path from reset_n.

Configuration
REQ-028 Macro PCQ_BRANCH_CNT_EN SHALL gate the taken-branch counter.
REQ-029 Defined: br_cnt increments on each edge with le=1, state=RUN, br_taken=1; saturates at 0xFF; cleared by reset.
REQ-030 Not defined: br_cnt SHALL be constant 0x00 and no counter flops SHALL be inferred; all other behaviour identical.

Verification
REQ-031 Reset then 3 edges le=1, no branch -> (b_pc,f_pc) = (0x04,0x08),(0x08,0x0C),(0x0C,0x10); squash=0.
REQ-032 f_pc=0x10, br_taken=1, ta=0x43, le=1 -> f_pc=0x40, b_pc=0x10; next edge b_pc=0x40, f_pc=0x44.
REQ-033 f_pc=0xFC, le=1 -> f_pc=0x00, b_pc=0xFC.
REQ-034 RUN, nullify_in=1, le=1 -> squash=1, state NULLIFY; le=0 two edges -> squash, PCs held; le=1 with br_taken=1, ta=0x80 -> branch ignored, f_pc+=4, squash=0.
REQ-035 le=0, reset_n=0 at f_pc=0x30, state NULLIFY -> b_pc=0x00, f_pc=0x04, squash=0, br_cnt=0x00.
REQ-036 With PCQ_BRANCH_CNT_EN, 257 taken branches in RUN -> br_cnt=0xFF; without macro -> br_cnt=0x00 throughout.
